// File: rtl/nexys_starship_pkg.sv
// nexys_starship_pkg: one-hot gunner state encodings and timing defaults
// shared by all four sector gunners.
package nexys_starship_pkg;
  localparam int TIMEOUT_DEFAULT = 200_000_000;
  localparam int COOLDOWN_DEFAULT = 25_000_000;
  localparam int TW_DEFAULT = 28;
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_ARMED  = 5'b00010,
    S_ENGAGE = 5'b00100,
    S_COOL   = 5'b01000,
    S_OVER   = 5'b10000
  } tg_state_t;
endpackage

// File: rtl/nexys_starship_cd_timer.sv
// nexys_starship_cd_timer: saturating down-counter with synchronous load;
// zero flags an expired (or cleared) count.
module nexys_starship_cd_timer #(
  parameter int TW = nexys_starship_pkg::TW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic          zero
);
  logic [TW-1:0] count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (load) count <= load_val;
    else if (en && count != '0) count <= count - TW'(1);
  end
  assign zero = count == '0;
endmodule

// File: rtl/nexys_starship_top_gunner.sv
// nexys_starship_top_gunner: player-side top-sector gunner enforcing the
// per-monster survival deadline and the post-shot weapon cooldown.
module nexys_starship_top_gunner
  import nexys_starship_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int COOLDOWN = COOLDOWN_DEFAULT,
  parameter int TW = TW_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic play_flag,
  input  logic q_TM_Full,
  input  logic fire_pulse,
  output logic top_monster_ctrl,
  output logic kill_pulse,
  output logic game_over,
  output logic cooldown_active,
  output logic q_TG_Idle,
  output logic q_TG_Armed,
  output logic q_TG_Engage,
  output logic q_TG_Cool,
  output logic q_TG_Over
);
  tg_state_t state, nxt;
  logic threat_run, threat_zero, cd_zero;
  logic go_idle, hit, miss, threat_exp, threat_ld;
  always_comb begin
    go_idle = !play_flag && state != S_IDLE;
    hit = play_flag && state == S_ENGAGE && fire_pulse;
    miss = play_flag && state == S_ARMED && fire_pulse && !q_TM_Full;
    threat_exp = threat_run && threat_zero;
    threat_ld = play_flag && (state == S_ARMED || state == S_COOL) && q_TM_Full && !threat_run;
    nxt = state;
    case (state)
      S_IDLE:   nxt = play_flag ? S_ARMED : S_IDLE;
      S_ARMED:  nxt = !play_flag ? S_IDLE : q_TM_Full ? S_ENGAGE : fire_pulse ? S_COOL : S_ARMED;
      S_ENGAGE: nxt = !play_flag ? S_IDLE : fire_pulse ? S_COOL : threat_exp ? S_OVER :
                      !q_TM_Full ? S_ARMED : S_ENGAGE;
      S_COOL:   nxt = !play_flag ? S_IDLE : threat_exp ? S_OVER : !cd_zero ? S_COOL :
                      (threat_run && q_TM_Full) ? S_ENGAGE : S_ARMED;
      S_OVER:   nxt = play_flag ? S_OVER : S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end
  // Leaving the game clears both counters; OVER freezes them in place.
  nexys_starship_cd_timer #(.TW(TW)) u_threat (
    .clk(Clk), .rst_n(Reset),
    .load(go_idle || threat_ld),
    .load_val(go_idle ? '0 : TW'(TIMEOUT - 1)),
    .en(threat_run && state != S_OVER),
    .zero(threat_zero)
  );
  nexys_starship_cd_timer #(.TW(TW)) u_cool (
    .clk(Clk), .rst_n(Reset),
    .load(go_idle || hit || miss),
    .load_val(go_idle ? '0 : TW'(COOLDOWN - 1)),
    .en(state != S_OVER),
    .zero(cd_zero)
  );
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
      threat_run <= 1'b0;
      top_monster_ctrl <= 1'b0;
      kill_pulse <= 1'b0;
      game_over <= 1'b0;
      cooldown_active <= 1'b0;
    end else begin
      state <= nxt;
      threat_run <= !(go_idle || hit || !q_TM_Full) && (threat_run || threat_ld);
      top_monster_ctrl <= nxt == S_ENGAGE;
      kill_pulse <= hit;
      game_over <= nxt == S_OVER;
      cooldown_active <= nxt == S_COOL;
    end
  end
  assign {q_TG_Over, q_TG_Cool, q_TG_Engage, q_TG_Armed, q_TG_Idle} = state;
endmodule

// File: doc/nexys_starship_top_gunner.md
Name: nexys_starship_top_gunner

Overview:
- Player-side counterpart of the top-sector monster controller. It watches the sector's monster-present status and the debounced top fire button.
- Drives the top_monster_ctrl hold/kill level back to the sector controller.
- Enforces a per-monster survival deadline; if the deadline expires, it raises game_over.
- Enforces a weapon cooldown after every shot, hit or miss.

Parameters:
- TIMEOUT, 200000000, cycles the player has to shoot a monster after it appears (2 s at 100 MHz).
- COOLDOWN, 25000000, cycles the weapon is disabled after any shot (250 ms).
- TW, 28, width of both down-counters; must hold max(TIMEOUT, COOLDOWN)-1.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- play_flag  in  1  game running; level.
- q_TM_Full  in  1  top sector holds a monster (one-hot state bit of sector controller).
- fire_pulse  in  1  debounced top button, single-cycle pulse.
- top_monster_ctrl  out  1  registered; 1 = hold monster alive, 0 = no monster / kill.
- kill_pulse  out  1  registered; one-cycle pulse on a successful hit (score increment).
- game_over  out  1  registered; latched deadline expiry.
- cooldown_active  out  1  registered; weapon disabled (drives LED).
- q_TG_Idle, q_TG_Armed, q_TG_Engage, q_TG_Cool, q_TG_Over  out  1 each  one-hot state bits.

Behaviour:
- Reset (Reset=0, asynchronous, any state):
  - State IDLE.
  - All outputs 0.
  - Both counters 0; threat_run = 0.
- All outputs are registered. Latency from any input event to the output change is 1 cycle.
- Threat counter:
  - Loaded with TIMEOUT-1 and threat_run set on the first cycle q_TM_Full=1 is seen in ARMED or COOL while threat_run=0.
  - Decrements each cycle while threat_run=1.
  - threat_run clears on kill, on q_TM_Full falling, or on entry to IDLE.
- Cooldown counter: loaded with COOLDOWN-1 on every accepted fire_pulse, then decrements to 0.
- IDLE:
  - ctrl=0, game_over=0.
  - play_flag=1 -> ARMED.
- ARMED:
  - ctrl=0.
  - q_TM_Full=1 -> ENGAGE, ctrl<=1, threat counter loaded.
  - fire_pulse with q_TM_Full=0 (miss) -> COOL.
  - If both occur in the same cycle, the monster wins: go to ENGAGE, fire is ignored.
- ENGAGE:
  - ctrl=1.
  - fire_pulse -> ctrl<=0, kill_pulse<=1 for one cycle, threat_run<=0, cooldown loaded, -> COOL.
  - Threat counter reaches 0 with no fire that cycle -> OVER, game_over<=1.
  - fire_pulse on the expiry cycle counts as a hit (fire wins).
  - q_TM_Full falls without a kill -> ARMED, ctrl<=0, no kill_pulse.
- COOL:
  - ctrl=0, cooldown_active=1.
  - fire_pulse is ignored and does not reload the cooldown.
  - A monster may appear during COOL; the threat counter loads and runs concurrently.
  - Cooldown reaches 0:
    - -> ENGAGE with the remaining threat count if threat_run=1 (ctrl<=1).
    - Otherwise -> ARMED.
  - Threat counter reaching 0 during COOL -> OVER, game_over<=1.
  - Simultaneous cooldown expiry and threat expiry -> OVER.
- OVER:
  - game_over held at 1, ctrl=0, counters frozen.
  - play_flag=0 -> IDLE, which clears game_over.
- play_flag=0 in ARMED, ENGAGE or COOL -> IDLE:
  - ctrl<=0, counters cleared.
  - No kill_pulse and no game_over.
- Counters never wrap: decrement saturates at 0.
- COOLDOWN=1 gives exactly 1 cycle in COOL.

Decomposition:
- Package nexys_starship_pkg holds:
  - The one-hot state encodings (IDLE=5'b00001 .. OVER=5'b10000).
  - Default TIMEOUT, COOLDOWN and TW constants, shared with the other three sector gunners.
- One sub-module: nexys_starship_cd_timer.
  - Parameterised TW-bit saturating down-counter with load, load_val, en, zero.
  - Instantiated twice: threat and cooldown.

Test Plan (TIMEOUT=20, COOLDOWN=5):
- Reset low mid-ENGAGE -> all outputs 0 and q_TG_Idle=1 in the same cycle, with no clock edge required; release, play_flag=1 -> q_TG_Armed one cycle later.
- q_TM_Full rises at cycle t, fire_pulse at t+10 -> ctrl=1 from t+1; at t+11 ctrl=0 and kill_pulse=1 for exactly one cycle; cooldown_active=1 for 5 cycles; then ARMED.
- q_TM_Full held, no fire -> game_over=1 exactly 21 cycles after q_TM_Full rise; remains 1 until play_flag=0, then 0 with IDLE next cycle.
- fire_pulse on the same cycle the threat counter hits 0 -> kill_pulse=1, game_over stays 0.
- Miss fire in ARMED, monster appears 2 cycles later -> stays COOL 3 more cycles, then ENGAGE with threat remaining 20-3=17; a second fire inside COOL is ignored (kill_pulse=0).
- play_flag dropped during COOL with threat running -> IDLE next cycle, game_over=0, ctrl=0, counters 0.
